rr_grant_ctrl: RTL and testbench
================================

Name: rr_grant_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one resource among N requesters.
- Issues exactly one grant at a time, holds it until the owner signals done or a hold timeout expires, then rotates priority.
- The grant vector is guaranteed one-hot or zero, so downstream mux/decode logic written with unique/unique0 if never sees overlapping or ambiguous selects.
- Sits between requester blocks and the shared datapath select.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release (1..255).
- IDW, $clog2(N), width of grant index (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request vector; bit i high = requester i wants the resource.
- done  in  1  current owner releases the resource; ignored unless in BUSY.
- gnt  out  N  registered grant vector; one-hot or all zero.
- gnt_valid  out  1  high while any grant is active (equals OR of gnt).
- gnt_id  out  IDW  index of the granted requester; holds last value when gnt_valid=0.
- timeout  out  1  one-cycle pulse when a grant is forcibly released by MAX_HOLD.
- busy_cnt  out  8  number of cycles the current grant has been held; 0 in IDLE.

Behaviour:
- Reset (async, any time, including mid-grant): gnt=0, gnt_valid=0, gnt_id=0, timeout=0, busy_cnt=0, rr pointer=0, state=IDLE. The grant drops immediately on rst assertion, not at the next edge.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE with all outputs idle.
  - If req!=0, select the first set bit searching upward from the rr pointer with wrap (pointer, pointer+1, ..., N-1, 0, ..., pointer-1).
  - At the next edge, gnt=one-hot of the winner, gnt_id=winner, gnt_valid=1, busy_cnt=1, state→BUSY.
  - Latency from req seen in IDLE to gnt is 1 cycle.
- BUSY:
  - gnt, gnt_id and gnt_valid are held constant. req changes, including the owner dropping its req, are ignored.
  - busy_cnt increments by 1 each cycle.
  - Release occurs on the first of:
    - done=1: normal release.
    - busy_cnt==MAX_HOLD with done=0: forced release; timeout=1 for exactly the cycle after release (the first IDLE cycle).
  - If done=1 and busy_cnt==MAX_HOLD in the same cycle, treat it as a normal release; timeout stays 0.
  - On release, at the next edge: gnt=0, gnt_valid=0, busy_cnt=0, rr pointer=(gnt_id+1) mod N, state→IDLE.
- Minimum one IDLE cycle between consecutive grants (bus-turnaround gap). Back-to-back grants to the same or different requesters are therefore spaced by at least one gnt_valid=0 cycle.
- done while in IDLE has no effect.
- Fairness: with all N requesting continuously, grants cycle 0,1,...,N-1,0,... Worst-case wait for any requester is (N-1)*(MAX_HOLD+1) cycles.
- Invariants: gnt is never multi-hot; gnt_valid==|gnt; when gnt_valid=1, gnt[gnt_id]==1.
- Pointer arithmetic wraps modulo N, including non-power-of-2 N.
- busy_cnt never exceeds MAX_HOLD.

Test Plan:
- Reset: hold rst=1 with req=4'b1111 → gnt=0, gnt_valid=0, busy_cnt=0. Release rst → first grant is gnt=4'b0001, gnt_id=0 one cycle later.
- Round-robin: req=4'b1111 held, done pulsed on 3rd BUSY cycle each grant → gnt_id sequence 0,1,2,3,0, with one gnt_valid=0 cycle between grants.
- Pointer skip: after a grant to id 1, req=4'b0001 → next grant is id 0 via wrap. Then req=4'b1001 → grant id 3.
- Timeout: N=4, MAX_HOLD=8, req=4'b0100, done never asserted → gnt=4'b0100 for 8 cycles with busy_cnt reaching 8. Next cycle gnt=0 and timeout=1 for exactly 1 cycle.
- Simultaneous release: done=1 on the cycle busy_cnt==8 → release with timeout=0. Owner drops req mid-BUSY → gnt still held until done.
- Async reset mid-grant: assert rst between edges while gnt=4'b0010 → gnt=0 immediately. After release with req=4'b0010, the pointer restarts at 0 and id 1 is granted.

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin arbiter/sequencer sharing one resource among N
// requesters. One grant at a time; the grant is held until the owner asserts
// done or the hold limit expires, then priority rotates past the owner.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (grant drops immediately)
//   req[N]     request vector, bit i = requester i wants the resource
//   done       owner releases the resource (only meaningful while BUSY)
//   gnt[N]     registered grant, one-hot or zero
//   gnt_valid  high while a grant is active (== |gnt)
//   gnt_id     index of granted requester, holds last value when idle
//   timeout    one-cycle pulse in the first IDLE cycle after a forced release
//   busy_cnt   cycles the current grant has been held, 0 when idle
module rr_grant_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout,
  output logic [7:0]     busy_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0]     MAX_CNT = 8'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);
  localparam logic [N-1:0]   ONE     = N'(1);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           release_now;

  // Wrapped priority search starting at ptr. Scanning offsets from high to
  // low and overwriting leaves the smallest offset (highest priority) winner,
  // so no early loop exit is needed.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[IDW-1:0];
      end
    end
  end

  // done wins over the hold limit, so a simultaneous hit is a normal release.
  assign release_now = done || (busy_cnt == MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
      busy_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt       <= ONE << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            busy_cnt  <= 8'd1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy_cnt  <= '0;
            ptr       <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            timeout   <= ~done;
            state     <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
module tb_rr_grant_ctrl;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic           done = 1'b0;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           timeout;
  logic [7:0]     busy_cnt;

  rr_grant_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .timeout(timeout), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: owner = -1 when nobody holds the resource.
  int m_owner = -1;
  int m_id    = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_to    = 0;
  int grants[$];
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_id = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic d);
    int w;
    m_to = 0;
    if (m_owner < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_id = w; m_cnt = 1; end
    end else if (d || m_cnt == MAX_HOLD) begin
      m_to    = !d;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    chk("gnt", 32'(gnt), exp_gnt);
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("gnt_id", 32'(gnt_id), 32'(m_id));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("busy_cnt", 32'(busy_cnt), 32'(m_cnt));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("valid_or", 32'(gnt_valid), 32'(|gnt));
  endtask

  // Drive one cycle's inputs (called at a negedge), advance, check at edge+1.
  task automatic step(input logic [N-1:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    if (!rst) model_update(r, d);
    #1;
    compare_all();
    if (gnt_valid && !prev_valid) grants.push_back(int'(gnt_id));
    prev_valid = gnt_valid;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    prev_valid = 1'b0;
  endtask

  initial begin
    // Reset held with all requesting: outputs stay idle.
    rst = 1'b1;
    @(negedge clk);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    rst = 1'b0;
    step(4'b1111, 1'b0);
    chk("first_gnt", 32'(gnt), 32'h1);

    // Round robin: done on 3rd BUSY cycle; expect 0,1,2,3,0.
    do_reset();
    grants.delete();
    for (int i = 0; i < 20; i++)
      step(4'b1111, (m_owner >= 0 && m_cnt == 3));
    chk("rr_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("rr_seq", 32'(grants[i]), 32'(i % N));

    // Pointer skip with wrap.
    do_reset();
    step(4'b0010, 1'b0);
    chk("skip_id1", 32'(gnt_id), 32'd1);
    step(4'b0010, 1'b1);
    step(4'b0001, 1'b0);
    chk("skip_wrap0", 32'(gnt_id), 32'd0);
    step(4'b0001, 1'b1);
    step(4'b1001, 1'b0);
    chk("skip_id3", 32'(gnt_id), 32'd3);
    step(4'b0000, 1'b1);

    // Timeout: hold without done.
    do_reset();
    step(4'b0100, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0100, 1'b0);
    chk("to_cnt_max", 32'(busy_cnt), 32'(MAX_HOLD));
    step(4'b0000, 1'b0);
    chk("to_pulse", 32'(timeout), 32'd1);
    step(4'b0000, 1'b0);
    chk("to_once", 32'(timeout), 32'd0);

    // Simultaneous done at the limit; owner drops req mid-grant.
    do_reset();
    step(4'b0100, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0000, 1'b0);
    chk("sim_held", 32'(gnt), 32'h4);
    step(4'b0000, 1'b1);
    chk("sim_no_to", 32'(timeout), 32'd0);
    chk("sim_rel", 32'(gnt_valid), 32'd0);

    // Async reset between edges drops the grant at once.
    do_reset();
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0010, 1'b0);
    chk("ar_pre", 32'(gnt), 32'h2);
    #2 rst = 1'b1;
    #1 chk("ar_drop", 32'(gnt), 32'h0);
    model_reset();
    @(negedge clk);
    step(4'b0010, 1'b0);
    rst = 1'b0;
    prev_valid = 1'b0;
    step(4'b0010, 1'b0);
    chk("ar_regrant", 32'(gnt_id), 32'd1);

    // Randomized traffic with occasional async resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rand_ar", 32'(gnt), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        prev_valid = 1'b0;
      end
      step(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
